// File: rtl/lut_mux_bank_if.sv
// Handshake/table-load bundle for lut_mux_bank.
// LUT_MUX_BANK_NEG_EN adds the per-channel in_neg request field.
interface lut_mux_bank_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 4
);
    logic                     lut_start;
    logic                     lut_wr_en;
    logic [DATA_W-1:0]        lut_wr_data;
    logic                     lut_ready;
    logic                     wr_err;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*SEL_W-1:0]  in_sel;
`ifdef LUT_MUX_BANK_NEG_EN
    logic [NUM_CH-1:0]        in_neg;
`endif
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;

`ifdef LUT_MUX_BANK_NEG_EN
    modport master (
        output lut_start, lut_wr_en, lut_wr_data, in_valid, in_sel, in_neg, out_ready,
        input  lut_ready, wr_err, in_ready, out_valid, out_data
    );
    modport slave (
        input  lut_start, lut_wr_en, lut_wr_data, in_valid, in_sel, in_neg, out_ready,
        output lut_ready, wr_err, in_ready, out_valid, out_data
    );
`else
    modport master (
        output lut_start, lut_wr_en, lut_wr_data, in_valid, in_sel, out_ready,
        input  lut_ready, wr_err, in_ready, out_valid, out_data
    );
    modport slave (
        input  lut_start, lut_wr_en, lut_wr_data, in_valid, in_sel, out_ready,
        output lut_ready, wr_err, in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/lut_mux_bank.sv
// Registered LUT lookup bank: serially loaded table, NUM_CH lookups per beat, 1-cycle latency.
// Optional LUT_MUX_BANK_NEG_EN: per-channel two's-complement negation of the looked-up entry.
module lut_mux_lane #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ld,
    input  logic [(1<<SEL_W)-1:0][DATA_W-1:0]    tbl,
    input  logic [SEL_W-1:0]                     sel,
    input  logic                                 neg,
    output logic [DATA_W-1:0]                    q
);
    logic [DATA_W-1:0] raw;

    assign raw = tbl[sel];

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= neg ? (~raw + DATA_W'(1)) : raw;
    end
endmodule

module lut_mux_bank #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 4
) (
    input  logic           clk,
    input  logic           rst,
    lut_mux_bank_if.slave  bus
);
    localparam int DEPTH = 1 << SEL_W;

    typedef enum logic [1:0] {EMPTY, LOAD, READY} st_t;

    st_t                            st, st_nxt;
    logic [SEL_W-1:0]               ptr;
    logic [DEPTH-1:0][DATA_W-1:0]   tbl;
    logic                           tbl_we, err_set, lut_ready;
    logic                           wr_err_q, out_valid_q, accept, in_ready;
    logic [NUM_CH-1:0]              neg;
    logic [NUM_CH-1:0][DATA_W-1:0]  out_data;

    always_ff @(posedge clk) begin
        if (rst)
            st <= EMPTY;
        else
            st <= st_nxt;
    end

    // lut_start is ignored in LOAD so a reload cannot be restarted mid-stream.
    always_comb begin
        st_nxt = st;
        case (st)
            EMPTY:   if (bus.lut_start) st_nxt = LOAD;
            LOAD:    if (bus.lut_wr_en && ptr == SEL_W'(DEPTH-1)) st_nxt = READY;
            READY:   if (bus.lut_start) st_nxt = LOAD;
            default: st_nxt = EMPTY;
        endcase
    end

    always_comb begin
        lut_ready = (st == READY);
        tbl_we    = (st == LOAD) && bus.lut_wr_en;
        err_set   = (st != LOAD) && bus.lut_wr_en;
    end

    assign in_ready = lut_ready & ~bus.lut_start & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            tbl         <= '0;
            wr_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (tbl_we) begin
                tbl[ptr] <= bus.lut_wr_data;
                ptr      <= ptr + SEL_W'(1);
            end else if (st != LOAD) begin
                ptr <= '0;
            end
            if (err_set)
                wr_err_q <= 1'b1;
            if (accept)
                out_valid_q <= 1'b1;
            else if (bus.out_ready)
                out_valid_q <= 1'b0;
        end
    end

`ifdef LUT_MUX_BANK_NEG_EN
    assign neg = bus.in_neg;
`else
    assign neg = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        lut_mux_lane #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_lane (
            .clk (clk),
            .rst (rst),
            .ld  (accept),
            .tbl (tbl),
            .sel (bus.in_sel[c*SEL_W +: SEL_W]),
            .neg (neg[c]),
            .q   (out_data[c])
        );
    end

    assign bus.lut_ready = lut_ready;
    assign bus.wr_err    = wr_err_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_lut_mux_bank.sv
// Directed bench for lut_mux_bank with a reference model and an output-beat scoreboard.
module tb_lut_mux_bank;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_mux_bank_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH)) bus ();

    lut_mux_bank #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0]        m_tbl [DEPTH];
    int                       m_st;
    logic [2:0]               m_ptr;
    logic                     m_ov, m_err;
    logic [NUM_CH*DATA_W-1:0] m_last;
    logic [NUM_CH*DATA_W-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        m_st = 0; m_ptr = '0; m_ov = 1'b0; m_err = 1'b0; m_last = '0;
        sb.delete();
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] look();
        logic [NUM_CH*DATA_W-1:0] r;
        logic [SEL_W-1:0]         s;
        logic [DATA_W-1:0]        v;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s = bus.in_sel[c*SEL_W +: SEL_W];
            v = m_tbl[s];
`ifdef LUT_MUX_BANK_NEG_EN
            if (bus.in_neg[c]) v = -v;
`endif
            r[c*DATA_W +: DATA_W] = v;
        end
        return r;
    endfunction

    // One clock: check all outputs against the model, then advance the model and the DUT.
    task automatic tick();
        logic exp_rdy, acc, cons;
        #1;
        exp_rdy = (m_st == 2) && !bus.lut_start && (!m_ov || bus.out_ready);
        chk("in_ready",  bus.in_ready,  exp_rdy);
        chk("out_valid", bus.out_valid, m_ov);
        chk("lut_ready", bus.lut_ready, m_st == 2);
        chk("wr_err",    bus.wr_err,    m_err);
        chk("out_data",  bus.out_data,  m_last);
        acc  = bus.in_valid && exp_rdy;
        cons = m_ov && bus.out_ready;
        if (cons) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $error("FAIL sb_empty observed=beat expected=none");
            end else begin
                chk("sb_beat", bus.out_data, sb.pop_front());
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            if (acc) begin
                m_last = look();
                sb.push_back(m_last);
                m_ov = 1'b1;
            end else if (cons) begin
                m_ov = 1'b0;
            end
            case (m_st)
                1: if (bus.lut_wr_en) begin
                    m_tbl[m_ptr] = bus.lut_wr_data;
                    if (m_ptr == 3'd7) m_st = 2;
                    m_ptr = m_ptr + 3'd1;
                end
                default: begin
                    if (bus.lut_wr_en) m_err = 1'b1;
                    if (bus.lut_start) begin m_st = 1; m_ptr = '0; end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] step);
        bus.lut_start = 1'b1;
        tick();
        bus.lut_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.lut_wr_en   = 1'b1;
            bus.lut_wr_data = base + DATA_W'(i) * step;
            tick();
        end
        bus.lut_wr_en = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.lut_start   = 1'b0;
        bus.lut_wr_en   = 1'b0;
        bus.lut_wr_data = '0;
        bus.in_valid    = 1'b0;
        bus.in_sel      = '0;
        bus.out_ready   = 1'b1;
`ifdef LUT_MUX_BANK_NEG_EN
        bus.in_neg      = '0;
`endif
        model_reset();
        @(posedge clk); #1;
        tick();
        rst = 1'b0;

        // No lookups accepted before the table is loaded
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel = 12'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;

        load_table(16'h0000, 16'h1111);

        // Directed lookup, held for one cycle by backpressure
        bus.in_sel    = {3'd7, 3'd0, 3'd5, 3'd2};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("first_beat", bus.out_data, 64'h7777_0000_5555_2222);
        tick();
        bus.out_ready = 1'b1;

        // Full-rate stream, then 3 cycles of stall
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel = 12'($urandom);
            tick();
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        // Write in READY: error flag, table untouched
        bus.lut_wr_en   = 1'b1;
        bus.lut_wr_data = 16'hDEAD;
        tick();
        bus.lut_wr_en = 1'b0;
        bus.in_sel    = {4{3'd3}};
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("idx3_after_err", bus.out_data, 64'h3333_3333_3333_3333);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wr_err", bus.wr_err, 1'b0);
        chk("rst_lut_ready", bus.lut_ready, 1'b0);

        // Start and write in the same EMPTY cycle: write dropped, error set
        bus.lut_start   = 1'b1;
        bus.lut_wr_en   = 1'b1;
        bus.lut_wr_data = 16'hBEEF;
        tick();
        bus.lut_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.lut_wr_data = DATA_W'(i) * 16'h1111;
            tick();
        end
        bus.lut_wr_en = 1'b0;

        // Reload while a beat is pending: beat keeps old data
        bus.in_sel    = {4{3'd1}};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        load_table(16'hA000, 16'h0001);
        chk("held_old_beat", bus.out_data, 64'h1111_1111_1111_1111);
        bus.out_ready = 1'b1;
        tick();
        bus.in_sel   = {4{3'd1}};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("idx1_new", bus.out_data, 64'hA001_A001_A001_A001);
        tick();

        // Reset in the middle of a load
        bus.lut_start = 1'b1;
        tick();
        bus.lut_start = 1'b0;
        bus.lut_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.lut_wr_data = 16'h5A00 + 16'(i);
            tick();
        end
        bus.lut_wr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

`ifdef LUT_MUX_BANK_NEG_EN
        bus.lut_start = 1'b1;
        tick();
        bus.lut_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.lut_wr_en   = 1'b1;
            bus.lut_wr_data = (i == 2) ? 16'h0003 : 16'(i);
            tick();
        end
        bus.lut_wr_en = 1'b0;
        bus.in_sel    = {3'd0, 3'd0, 3'd0, 3'd2};
        bus.in_neg    = 4'b0001;
        bus.in_valid  = 1'b1;
        tick();
        chk("neg_ch0", bus.out_data[15:0], 16'hFFFD);
        bus.in_neg = 4'b0000;
        tick();
        bus.in_valid = 1'b0;
        chk("raw_ch0", bus.out_data[15:0], 16'h0003);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_mux_bank.md
Name: lut_mux_bank

Overview:
- Parametrised, registered lookup stage for the bit-serial LUT multiply datapath.
- Holds an internal table of 2^SEL_W entries, each DATA_W bits wide, loaded serially by a small load state machine.
- Serves NUM_CH parallel channel lookups per beat, with a 1-cycle latency valid/ready pipeline.
- Sits between the LUT precompute stage (table writer) and the partial-sum accumulators (output consumer).

Parameters:
- DATA_W, 16, width of each LUT entry and each channel output
- SEL_W, 3, select width; table depth DEPTH = 2^SEL_W
- NUM_CH, 4, number of parallel lookup channels per beat

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- lut_start  input  1  pulse; begins a table (re)load
- lut_wr_en  input  1  table write strobe, valid only in LOAD
- lut_wr_data  input  DATA_W  entry data; address auto-increments from 0
- lut_ready  output  1  table fully loaded (state READY)
- wr_err  output  1  sticky flag: lut_wr_en seen outside LOAD
- in_valid  input  1  lookup request valid
- in_ready  output  1  lookup request accepted this cycle when high with in_valid
- in_sel  input  NUM_CH*SEL_W  channel c select at bits [c*SEL_W +: SEL_W]
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts output
- out_data  output  NUM_CH*DATA_W  channel c result at bits [c*DATA_W +: DATA_W]

Behaviour:
- Reset (clk edge with rst=1):
  - state=EMPTY; lut_ready=0, wr_err=0, out_valid=0, out_data=0, write pointer=0.
  - Table contents are cleared to 0.
- States:
  - EMPTY: lut_start -> LOAD.
  - LOAD: each lut_wr_en writes lut_wr_data to table[ptr], then ptr++. The write with ptr=DEPTH-1 -> READY, ptr wraps to 0.
  - READY: lut_start -> LOAD with ptr=0.
- lut_ready = (state==READY).
- LOAD ignores lut_start (no restart); writes continue from the current ptr.
- Same-cycle lut_start and lut_wr_en in EMPTY/READY: the write is ignored and wr_err is set.
- wr_err: set by lut_wr_en in EMPTY or READY; cleared only by rst.
- in_ready = lut_ready & ~lut_start & (~out_valid | out_ready); combinational.
- Accept (in_valid & in_ready):
  - Next edge loads out_data[c] = table[in_sel[c]] for every channel, and out_valid=1.
  - Latency is exactly 1 cycle.
- out_valid & out_ready & no accept: out_valid->0 and out_data holds its last value.
- Back-to-back accepts at full rate are supported when out_ready is held high.
- out_valid & ~out_ready: out_data and out_valid hold stable; in_ready=0.
- Reload while out_valid is pending: the output beat is held until consumed; its data reflects the old table.
- Lookup uses the table as of the accept cycle. No write can coincide with an accept, because in_ready=0 in LOAD.
- Select values always lie in 0..DEPTH-1; there is no out-of-range case.
- rst mid-LOAD or with out_valid pending discards everything and returns to the reset state.

Optional Feature:
- Macro: LUT_MUX_BANK_NEG_EN.
- Defined:
  - Adds input port in_neg [NUM_CH-1:0], sampled on accept.
  - Channel c output = two's-complement negation of table[in_sel[c]] (modulo 2^DATA_W) when in_neg[c]=1, otherwise the raw entry.
  - Used for the MSB (sign) bit of signed bit-serial weights.
  - Latency is unchanged at 1 cycle.
- Undefined: port absent; outputs are always the raw entries.

Test Plan:
- Reset then drive in_valid=1 -> in_ready=0, out_valid=0, lut_ready=0 for all cycles until a load completes.
- Pulse lut_start, then write 8 entries 0x0000,0x1111,...,0x7777 (DATA_W=16, SEL_W=3).
  - lut_ready rises on the edge of the 8th write.
  - in_sel={3'd7,3'd0,3'd5,3'd2} -> one cycle later out_data={0x7777,0x0000,0x5555,0x2222}, out_valid=1.
- Stream 4 back-to-back requests with out_ready=1 -> 4 consecutive valid beats, no bubbles.
  - Then hold out_ready=0 for 3 cycles -> out_data stable and in_ready=0 throughout.
- lut_wr_en pulsed in READY -> wr_err=1 and the table is unchanged (re-lookup of index 3 returns 0x3333). Assert rst -> wr_err=0 and lut_ready=0.
- With out_valid pending, pulse lut_start and write 8 new entries 0xA000+i.
  - The held beat still shows the old data.
  - After the reload, index 1 returns 0xA001.
- With LUT_MUX_BANK_NEG_EN defined: entry 2=0x0003, in_neg[0]=1, in_sel[0]=2 -> out_data[15:0]=0xFFFD; in_neg[0]=0 -> 0x0003.
